// File: rtl/anita3_trigger_arbiter.sv
// Trigger arbiter: latches enabled source edges, prescales RF, and grants one source at a time by fixed priority.
// Optional feature macro: TRIG_ARB_DROP_COUNT_EN builds the saturating lost-request counter on dropped_o.
module anita3_trigger_arbiter #(
  parameter int NUM_SRC        = 4,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int PRESCALE_W     = 8
) (
  input  logic                  clk250_i,
  input  logic                  rst_n_i,
  input  logic [NUM_SRC-1:0]    req_i,
  input  logic [NUM_SRC-1:0]    src_en_i,
  input  logic [PRESCALE_W-1:0] rf_prescale_i,
  input  logic                  dead_i,
  output logic [NUM_SRC-1:0]    trig_o,
  output logic [NUM_SRC-1:0]    pending_o,
  output logic                  busy_o,
  output logic [15:0]           dropped_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLDOFF
  } state_t;

  localparam logic [PRESCALE_W-1:0] PS_ONE    = PRESCALE_W'(1);
  localparam logic [7:0]            HOLD_LOAD = 8'(HOLDOFF_CYCLES - 1);

  state_t                  state_q;
  logic [NUM_SRC-1:0]      req_q;
  logic [NUM_SRC-1:0]      pending_q, pending_d;
  logic [NUM_SRC-1:0]      trig_q;
  logic                    busy_q;
  logic [7:0]              hcnt_q;
  logic [PRESCALE_W-1:0]   pscnt_q, pscnt_d;

  logic [NUM_SRC-1:0]      edge_w, set_w, gclr_w, avail_w, pick_oh;
  logic                    rf_pass, can_issue;

  assign edge_w  = req_i & ~req_q & src_en_i;
  assign rf_pass = edge_w[0] & (pscnt_q >= rf_prescale_i);

  always_comb begin
    set_w    = edge_w;
    set_w[0] = rf_pass;
    pscnt_d  = pscnt_q;
    if (edge_w[0]) pscnt_d = rf_pass ? '0 : pscnt_q + PS_ONE;
  end

  // trig_q is non-zero only in ISSUE, so it doubles as the grant-clear mask; a new set wins over it.
  assign gclr_w    = trig_q;
  assign pending_d = (pending_q & ~gclr_w & src_en_i) | set_w;
  assign avail_w   = pending_q & src_en_i;
  assign can_issue = (|avail_w) & ~dead_i;

  always_comb begin
    pick_oh = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (avail_w[i]) begin
        pick_oh    = '0;
        pick_oh[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      req_q     <= '0;
      pending_q <= '0;
      pscnt_q   <= '0;
    end else begin
      req_q     <= req_i;
      pending_q <= pending_d;
      pscnt_q   <= pscnt_d;
    end
  end

  // The last holdoff cycle re-arbitrates so back-to-back grants are exactly HOLDOFF_CYCLES+1 apart.
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      trig_q  <= '0;
      busy_q  <= 1'b0;
      hcnt_q  <= '0;
    end else begin
      trig_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (can_issue) begin
            trig_q  <= pick_oh;
            busy_q  <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          hcnt_q  <= HOLD_LOAD;
          state_q <= ST_HOLDOFF;
        end
        ST_HOLDOFF: begin
          if (hcnt_q == '0) begin
            if (can_issue) begin
              trig_q  <= pick_oh;
              state_q <= ST_ISSUE;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else begin
            hcnt_q <= hcnt_q - 8'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef TRIG_ARB_DROP_COUNT_EN
  logic [15:0] drop_q;
  logic        drop_any;

  assign drop_any = |(set_w & pending_q & ~gclr_w);

  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      drop_q <= '0;
    end else if (drop_any && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign dropped_o = drop_q;
`else
  assign dropped_o = 16'h0000;
`endif

  assign trig_o    = trig_q;
  assign pending_o = pending_q;
  assign busy_o    = busy_q;

endmodule
